// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake and iterative unsigned MULU/DIVU
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; in_ready is high only while idle
//   opA, opB, sel       operands and op select (captured on accept)
//   out_valid/out_ready result handshake; outputs hold while out_valid is high
//   res, res_hi         result low word/quotient, high product word/remainder
//   z, c, v, err        zero, carry, signed overflow, illegal op or divide-by-zero
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             err
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_nx;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               div_q, div_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   res_q, res_d, res_hi_q, res_hi_d;
    logic               z_q, z_d, c_q, c_d, v_q, v_d, err_q, err_d;

    logic [WIDTH:0]     add_s, sub_s, mul_s, div_r;
    logic [WIDTH-1:0]   div_rem, alu_r;
    logic               div_ge, alu_c, alu_v, alu_e;

    // single-cycle ops, evaluated straight from the request inputs
    always_comb begin
        add_s = {1'b0, opA} + {1'b0, opB};
        sub_s = {1'b0, opA} + {1'b0, ~opB} + {{WIDTH{1'b0}}, 1'b1};
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        alu_e = 1'b0;
        case (sel)
            4'h0: begin
                alu_r = add_s[WIDTH-1:0];
                alu_c = add_s[WIDTH];
                alu_v = (opA[WIDTH-1] == opB[WIDTH-1]) && (add_s[WIDTH-1] != opA[WIDTH-1]);
            end
            4'h1: begin
                alu_r = sub_s[WIDTH-1:0];
                alu_c = sub_s[WIDTH];
                alu_v = (opA[WIDTH-1] != opB[WIDTH-1]) && (sub_s[WIDTH-1] != opA[WIDTH-1]);
            end
            4'h2: alu_r = opA & opB;
            4'h3: alu_r = opA | opB;
            4'h4: alu_r = ~opA;
            4'h5: alu_r = opA ^ opB;
            4'h6: alu_r = {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
            4'h7: alu_r = {{(WIDTH-1){1'b0}}, opA < opB};
            default: alu_e = 1'b1;
        endcase
    end

    // one iteration step; acc holds {high, low}: for MULU {partial, multiplier},
    // for DIVU {remainder, dividend/quotient}. With a zero divisor every trial
    // subtract succeeds, leaving quotient all ones and remainder equal to opA.
    always_comb begin
        mul_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_r   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge  = div_r >= {1'b0, b_q};
        div_rem = div_ge ? WIDTH'(div_r - {1'b0, b_q}) : div_r[WIDTH-1:0];
        acc_nx  = div_q ? {div_rem, acc_q[WIDTH-2:0], div_ge} : {mul_s, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        div_d    = div_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                if (sel[3:1] == 3'b100) begin
                    state_d = BUSY;
                    div_d   = sel[0];
                    b_d     = opB;
                    acc_d   = {{WIDTH{1'b0}}, opA};
                    cnt_d   = '0;
                end else begin
                    state_d  = DONE;
                    res_d    = alu_r;
                    res_hi_d = '0;
                    z_d      = alu_r == '0;
                    c_d      = alu_c;
                    v_d      = alu_v;
                    err_d    = alu_e;
                end
            end
            BUSY: begin
                acc_d = acc_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    res_d    = acc_nx[WIDTH-1:0];
                    res_hi_d = acc_nx[2*WIDTH-1:WIDTH];
                    z_d      = acc_nx[WIDTH-1:0] == '0;
                    c_d      = 1'b0;
                    v_d      = 1'b0;
                    err_d    = div_q && (b_q == '0);
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = state_d == IDLE;
        out_valid_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            div_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            res_hi_q    <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            div_q       <= div_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            res_hi_q    <= res_hi_d;
            z_q         <= z_d;
            c_q         <= c_d;
            v_q         <= v_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign z         = z_q;
    assign c         = c_q;
    assign v         = v_q;
    assign err       = err_q;
endmodule
